// File: rtl/apb_dec_pkg.sv
// Shared constants, state type and region-match helper for the APB address decoder.
// The error-log option is selected by APB_DEC_ERRLOG_EN in apb_addr_decoder_n.
package apb_dec_pkg;

  localparam int MAX_SLV = 16;
  localparam int MAX_AW  = 64;

  localparam logic [31:0] SLV1_BASE   = 32'h0001_F000;
  localparam logic [31:0] SLV2_BASE   = 32'h0002_F000;
  localparam logic [31:0] SLV_MASK_4K = 32'hFFFF_F000;

  typedef enum logic {
    DEC_EMPTY = 1'b0,
    DEC_FULL  = 1'b1
  } dec_state_e;

  // Operands are zero-extended to MAX_AW by the caller so one helper serves every width.
  function automatic logic slv_match(input logic [MAX_AW-1:0] addr,
                                     input logic [MAX_AW-1:0] base,
                                     input logic [MAX_AW-1:0] mask);
    return ((addr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/apb_dec_match.sv
// Combinational priority matcher: returns a one-hot select for the lowest-index
// region containing the address, plus a hit flag.
module apb_dec_match
  import apb_dec_pkg::*;
#(
  parameter int                            ADDR_WIDTH = 32,
  parameter int                            NUM_SLV    = 2,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE   = {SLV2_BASE, SLV1_BASE},
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK   = {SLV_MASK_4K, SLV_MASK_4K}
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_SLV-1:0]    o_psel,
  output logic                  o_hit
);

  logic [MAX_AW-1:0] w_addr;
  logic [MAX_AW-1:0] w_base;
  logic [MAX_AW-1:0] w_mask;
  logic              w_match;

  // Walk regions in index order; once a hit is seen later regions are masked off.
  always_comb begin
    o_psel  = '0;
    o_hit   = 1'b0;
    w_addr  = '0;
    w_base  = '0;
    w_mask  = '0;
    w_match = 1'b0;
    w_addr[ADDR_WIDTH-1:0] = i_addr;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_base = '0;
      w_mask = '0;
      w_base[ADDR_WIDTH-1:0] = SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_mask[ADDR_WIDTH-1:0] = SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_match   = slv_match(w_addr, w_base, w_mask);
      o_psel[i] = w_match && !o_hit;
      o_hit     = o_hit || w_match;
    end
  end

endmodule

// File: rtl/apb_addr_decoder_n.sv
// N-slave APB address decoder with one registered stage, valid/ready handshake,
// saturating miss counter and an optional first-miss log (APB_DEC_ERRLOG_EN).
module apb_addr_decoder_n
  import apb_dec_pkg::*;
#(
  parameter int                            ADDR_WIDTH  = 32,
  parameter int                            NUM_SLV     = 2,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE    = {SLV2_BASE, SLV1_BASE},
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK    = {SLV_MASK_4K, SLV_MASK_4K},
  parameter int                            MISS_TO_ERR = 1,
  parameter int                            CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [ADDR_WIDTH-1:0] dec_addr_o,
  output logic [NUM_SLV-1:0]    dec_psel_o,
  output logic                  dec_err_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o,
`ifdef APB_DEC_ERRLOG_EN
  output logic                  err_log_valid_o,
  output logic [ADDR_WIDTH-1:0] err_log_addr_o,
`endif
  input  logic                  cnt_clr_i
);

  localparam logic [NUM_SLV-1:0] MISS_PSEL = NUM_SLV'(1);

  dec_state_e            r_state;
  dec_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NUM_SLV-1:0]    r_psel;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [NUM_SLV-1:0]    w_psel_hit;
  logic [NUM_SLV-1:0]    w_psel;
  logic                  w_hit;
  logic                  w_err;
  logic                  w_accept;
  logic                  w_miss;

  apb_dec_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLV    (NUM_SLV),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_match (
    .i_addr (req_addr_i),
    .o_psel (w_psel_hit),
    .o_hit  (w_hit)
  );

  assign req_ready_o = (r_state == DEC_EMPTY) || dec_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_miss      = w_accept && !w_hit;

  // Unmapped addresses either raise an error with no select or fall back to slave 0.
  always_comb begin
    w_psel = w_psel_hit;
    w_err  = 1'b0;
    if (!w_hit) begin
      if (MISS_TO_ERR != 0) begin
        w_psel = '0;
        w_err  = 1'b1;
      end else begin
        w_psel = MISS_PSEL;
        w_err  = 1'b0;
      end
    end else begin
      w_psel = w_psel_hit;
      w_err  = 1'b0;
    end
  end

  // Next state of the output slot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DEC_EMPTY: begin
        if (w_accept) w_state_nxt = DEC_FULL;
        else          w_state_nxt = DEC_EMPTY;
      end
      DEC_FULL: begin
        if (dec_ready_i && !w_accept) w_state_nxt = DEC_EMPTY;
        else                          w_state_nxt = DEC_FULL;
      end
      default: w_state_nxt = DEC_EMPTY;
    endcase
  end

  // Output slot state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= DEC_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Payload loads only on acceptance, so it holds through a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_psel <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_addr <= req_addr_i;
      r_psel <= w_psel;
      r_err  <= w_err;
    end else begin
      r_addr <= r_addr;
      r_psel <= r_psel;
      r_err  <= r_err;
    end
  end

  // Saturating miss counter; a clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (cnt_clr_i)              r_cnt <= '0;
    else if (w_miss && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
    else                             r_cnt <= r_cnt;
  end

  assign dec_valid_o = (r_state == DEC_FULL);
  assign dec_addr_o  = r_addr;
  assign dec_psel_o  = r_psel;
  assign dec_err_o   = r_err;
  assign miss_cnt_o  = r_cnt;

`ifdef APB_DEC_ERRLOG_EN
  logic                  r_log_valid;
  logic [ADDR_WIDTH-1:0] r_log_addr;

  // Sticky capture of the first unmapped address since the last clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_log_valid <= 1'b0;
      r_log_addr  <= '0;
    end else if (cnt_clr_i) begin
      r_log_valid <= 1'b0;
      r_log_addr  <= '0;
    end else if (w_miss && !r_log_valid) begin
      r_log_valid <= 1'b1;
      r_log_addr  <= req_addr_i;
    end else begin
      r_log_valid <= r_log_valid;
      r_log_addr  <= r_log_addr;
    end
  end

  assign err_log_valid_o = r_log_valid;
  assign err_log_addr_o  = r_log_addr;
`else
  // No error-log state in this build.
`endif

endmodule

// File: tb/tb_apb_addr_decoder_n.sv
// Self-checking bench: two decoder instances (default regions with 4-bit counter,
// and an overlapping-region fall-back configuration) against a behavioural model.
module tb_apb_addr_decoder_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        dec_ready = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        a_ready, a_valid, a_err, b_ready, b_valid, b_err;
  logic [31:0] a_addr, b_addr;
  logic [1:0]  a_psel, b_psel;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;
`ifdef APB_DEC_ERRLOG_EN
  logic        a_log_v, b_log_v;
  logic [31:0] a_log_a, b_log_a;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_addr_decoder_n #(.CNT_WIDTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(a_ready), .dec_valid_o(a_valid), .dec_ready_i(dec_ready),
    .dec_addr_o(a_addr), .dec_psel_o(a_psel), .dec_err_o(a_err), .miss_cnt_o(a_cnt),
`ifdef APB_DEC_ERRLOG_EN
    .err_log_valid_o(a_log_v), .err_log_addr_o(a_log_a),
`endif
    .cnt_clr_i(cnt_clr)
  );

  apb_addr_decoder_n #(
    .MISS_TO_ERR(0),
    .SLV_BASE({32'h0000_F000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_F000, 32'hFFFF_0000})
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(b_ready), .dec_valid_o(b_valid), .dec_ready_i(dec_ready),
    .dec_addr_o(b_addr), .dec_psel_o(b_psel), .dec_err_o(b_err), .miss_cnt_o(b_cnt),
`ifdef APB_DEC_ERRLOG_EN
    .err_log_valid_o(b_log_v), .err_log_addr_o(b_log_a),
`endif
    .cnt_clr_i(cnt_clr)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] cfg_base [2][2] = '{'{32'h0001_F000, 32'h0002_F000}, '{32'h0000_0000, 32'h0000_F000}};
  logic [31:0] cfg_mask [2][2] = '{'{32'hFFFF_F000, 32'hFFFF_F000}, '{32'hFFFF_0000, 32'hFFFF_F000}};
  bit          cfg_m2e  [2]    = '{1'b1, 1'b0};
  int          cfg_cmax [2]    = '{15, 65535};

  logic        m_valid = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [1:0]  m_psel [2] = '{2'b00, 2'b00};
  logic        m_err  [2] = '{1'b0, 1'b0};
  int          m_cnt  [2] = '{0, 0};
  logic        m_logv [2] = '{1'b0, 1'b0};
  logic [31:0] m_loga [2] = '{32'h0, 32'h0};

  function automatic int exp_idx(input int d, input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if ((a & cfg_mask[d][i]) == (cfg_base[d][i] & cfg_mask[d][i])) return i;
    return -1;
  endfunction

  function automatic logic [1:0] exp_psel(input int d, input logic [31:0] a);
    int k;
    k = exp_idx(d, a);
    if (k >= 0) return 2'(1 << k);
    return cfg_m2e[d] ? 2'b00 : 2'b01;
  endfunction

  function automatic logic is_miss(input int d, input logic [31:0] a);
    return exp_idx(d, a) < 0;
  endfunction

  function automatic logic accepting();
    return req_valid && (!m_valid || dec_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_addr  <= 32'h0;
      for (int d = 0; d < 2; d++) begin
        m_psel[d] <= 2'b00; m_err[d] <= 1'b0; m_cnt[d] <= 0;
        m_logv[d] <= 1'b0;  m_loga[d] <= 32'h0;
      end
    end else begin
      if (accepting()) begin
        m_valid <= 1'b1;
        m_addr  <= req_addr;
      end else if (dec_ready) begin
        m_valid <= 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        if (accepting()) begin
          m_psel[d] <= exp_psel(d, req_addr);
          m_err[d]  <= is_miss(d, req_addr) && cfg_m2e[d];
        end
        if (cnt_clr) begin
          m_cnt[d] <= 0; m_logv[d] <= 1'b0; m_loga[d] <= 32'h0;
        end else if (accepting() && is_miss(d, req_addr)) begin
          if (m_cnt[d] < cfg_cmax[d]) m_cnt[d] <= m_cnt[d] + 1;
          if (!m_logv[d]) begin m_logv[d] <= 1'b1; m_loga[d] <= req_addr; end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("a_valid", 64'(a_valid), 64'(m_valid));
    chk("b_valid", 64'(b_valid), 64'(m_valid));
    chk("a_ready", 64'(a_ready), 64'(!m_valid || dec_ready));
    chk("b_ready", 64'(b_ready), 64'(!m_valid || dec_ready));
    chk("a_cnt", 64'(a_cnt), 64'(m_cnt[0]));
    chk("b_cnt", 64'(b_cnt), 64'(m_cnt[1]));
    if (m_valid) begin
      chk("a_addr", 64'(a_addr), 64'(m_addr));
      chk("b_addr", 64'(b_addr), 64'(m_addr));
      chk("a_psel", 64'(a_psel), 64'(m_psel[0]));
      chk("b_psel", 64'(b_psel), 64'(m_psel[1]));
      chk("a_err", 64'(a_err), 64'(m_err[0]));
      chk("b_err", 64'(b_err), 64'(m_err[1]));
    end
`ifdef APB_DEC_ERRLOG_EN
    chk("a_logv", 64'(a_log_v), 64'(m_logv[0]));
    chk("b_logv", 64'(b_log_v), 64'(m_logv[1]));
    chk("a_loga", 64'(a_log_a), 64'(m_loga[0]));
    chk("b_loga", 64'(b_log_a), 64'(m_loga[1]));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic r, input logic c);
    req_valid = v; req_addr = a; dec_ready = r; cnt_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_addr [6] = '{32'h0002_F123, 32'h0000_0010, 32'h0000_F00C,
                                32'h0001_FFFF, 32'h1234_5678, 32'h0002_F000};

  initial begin
    drive(1'b1, 32'h0001_F004, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_psel", 64'(a_psel), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd1);
    rst_n = 1'b1;

    drive(1'b1, 32'h0001_F004, 1'b1, 1'b0); tick();
    chk("slv0_psel", 64'(a_psel), 64'h1);
    chk("slv0_err", 64'(a_err), 64'd0);
    drive(1'b1, 32'h0002_FFFC, 1'b1, 1'b0); tick();
    chk("slv1_valid", 64'(a_valid), 64'd1);
    chk("slv1_psel", 64'(a_psel), 64'h2);
    chk("slv1_addr", 64'(a_addr), 64'h0002_FFFC);

    drive(1'b1, 32'h0003_0000, 1'b1, 1'b0); tick();
    chk("miss_err_psel", 64'(a_psel), 64'h0);
    chk("miss_err_err", 64'(a_err), 64'd1);
    chk("miss_err_cnt", 64'(a_cnt), 64'd1);
    chk("miss_s0_psel", 64'(b_psel), 64'h1);
    chk("miss_s0_err", 64'(b_err), 64'd0);
    chk("miss_s0_cnt", 64'(b_cnt), 64'd3);

    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk("empty_valid", 64'(a_valid), 64'd0);

    drive(1'b1, 32'h0001_F010, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0002_F000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ready", 64'(a_ready), 64'd0);
      chk("stall_addr", 64'(a_addr), 64'h0001_F010);
      chk("stall_psel", 64'(a_psel), 64'h1);
    end
    drive(1'b1, 32'h0002_F000, 1'b1, 1'b0); tick();
    chk("replace_valid", 64'(a_valid), 64'd1);
    chk("replace_psel", 64'(a_psel), 64'h2);

    drive(1'b1, 32'h0000_F100, 1'b1, 1'b0); tick();
    chk("overlap_psel", 64'(b_psel), 64'h1);
    chk("overlap_a_err", 64'(a_err), 64'd1);

    drive(1'b1, 32'h0003_0000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 64'(a_cnt), 64'd15);
    chk("wide_cnt", 64'(b_cnt), 64'd25);
    drive(1'b1, 32'h0003_0000, 1'b1, 1'b1); tick();
    chk("clr_wins", 64'(a_cnt), 64'd0);

    drive(1'b1, 32'h5000_0000, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h6000_0000, 1'b1, 1'b0); tick();
    chk("post_clr_cnt", 64'(a_cnt), 64'd2);
`ifdef APB_DEC_ERRLOG_EN
    chk("log_valid", 64'(a_log_v), 64'd1);
    chk("log_first", 64'(a_log_a), 64'h5000_0000);
`endif

    drive(1'b1, 32'h0001_F020, 1'b0, 1'b0); tick(); tick();
    rst_n = 1'b0; tick();
    chk("mid_rst_valid", 64'(a_valid), 64'd0);
    chk("mid_rst_psel", 64'(a_psel), 64'd0);
    chk("mid_rst_addr", 64'(a_addr), 64'd0);
    chk("mid_rst_cnt", 64'(b_cnt), 64'd0);
    chk("mid_rst_ready", 64'(a_ready), 64'd1);
`ifdef APB_DEC_ERRLOG_EN
    chk("mid_rst_log", 64'(a_log_v), 64'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive((i % 4) != 3, vec_addr[i % 6], (i % 3) != 0, i == 11);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
